// File: rtl/mult32_seq_if.sv
// Handshake and operand/result bundle between the ALU control FSM and mult32_seq.
interface mult32_seq_if;
    logic        start;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    // Requester side: issues operands, observes results.
    modport master (
        output start, is_signed, a, b,
        input  hi, lo, busy, done
    );

    // Multiplier side.
    modport slave (
        input  start, is_signed, a, b,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/mult32_seq.sv
// Iterative 32x32->64 shift-and-add multiplier, one multiplier bit per clock.
// Signed operands are multiplied as magnitudes and the product negated at the end.

// Logarithmic barrel shifter: lnr=1 shifts left, lnr=0 shifts right (logical), by s.
module shift32 (
    input  logic [31:0] din,
    input  logic [4:0]  s,
    input  logic        lnr,
    output logic [31:0] dout
);
    logic [31:0] stg [0:5];

    assign stg[0] = din;

    // Each stage conditionally shifts by 2**i.
    for (genvar i = 0; i < 5; i++) begin : g_stage
        assign stg[i+1] = !s[i] ? stg[i] :
                          lnr   ? (stg[i] << (2 ** i)) :
                                  (stg[i] >> (2 ** i));
    end

    assign dout = stg[5];
endmodule

module mult32_seq (
    input logic          clk,
    input logic          rst,
    mult32_seq_if.slave  bus
);
    typedef enum logic [1:0] {StIdle, StRun, StFix, StFin} state_e;

    state_e      state_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] ma_q;
    logic        neg_q;
    logic [4:0]  cnt_q;
    logic        busy_q;
    logic        done_q;

    logic        load;
    logic [31:0] ma_d;
    logic [31:0] mb_d;
    logic        neg_d;
    logic [32:0] hi_sum;
    logic [31:0] hi_shr;
    logic [31:0] lo_shr;
    logic [31:0] hi_iter;
    logic [31:0] lo_iter;
    logic [63:0] prod_neg;
    logic        unused_bits;

    // Operand capture: magnitudes and result sign. 0x80000000 stays 0x80000000 (2^31).
    always_comb begin
        ma_d  = (bus.is_signed && bus.a[31]) ? (~bus.a + 32'd1) : bus.a;
        mb_d  = (bus.is_signed && bus.b[31]) ? (~bus.b + 32'd1) : bus.b;
        neg_d = bus.is_signed & (bus.a[31] ^ bus.b[31]);
        // The FIN exit edge also acts as an IDLE load edge, giving one product per 34 cycles.
        load  = bus.start && ((state_q == StIdle) || (state_q == StFin));
    end

    // One iteration: conditional add into a 33-bit sum whose carry refills HI's top bit.
    always_comb begin
        hi_sum = lo_q[0] ? ({1'b0, hi_q} + {1'b0, ma_q}) : {1'b0, hi_q};
    end

    shift32 u_shift_hi (
        .din  (hi_sum[31:0]),
        .s    (5'd1),
        .lnr  (1'b0),
        .dout (hi_shr)
    );

    shift32 u_shift_lo (
        .din  (lo_q),
        .s    (5'd1),
        .lnr  (1'b0),
        .dout (lo_shr)
    );

    // Splice the bits shifted in from above into the vacated MSBs.
    always_comb begin
        hi_iter     = {hi_sum[32], hi_shr[30:0]};
        lo_iter     = {hi_sum[0], lo_shr[30:0]};
        prod_neg    = ~{hi_q, lo_q} + 64'd1;
        unused_bits = hi_shr[31] ^ lo_shr[31];
    end

    // Control FSM and datapath registers; BUSY/DONE registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            hi_q    <= '0;
            lo_q    <= '0;
            ma_q    <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StFin: begin
                    if (load) begin
                        state_q <= StRun;
                        hi_q    <= '0;
                        lo_q    <= mb_d;
                        ma_q    <= ma_d;
                        neg_q   <= neg_d;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                    done_q <= 1'b0;
                end
                StRun: begin
                    hi_q  <= hi_iter;
                    lo_q  <= lo_iter;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    if (neg_q) begin
                        {hi_q, lo_q} <= prod_neg;
                    end
                    state_q <= StFin;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_mult32_seq.sv
// Self-checking bench for mult32_seq: directed corners, random products against
// a plain-arithmetic reference, back-to-back issue and mid-run reset.
module tb_mult32_seq;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    mult32_seq_if bus ();

    mult32_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference product from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        return ua * ub;
    endfunction

    // Issue one operation (load at edge 0) and watch 40 edges; no checking here.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          output logic [31:0] hi, output logic [31:0] lo,
                          output int lat, output int ndone, output int bad_busy);
        lat      = -1;
        ndone    = 0;
        bad_busy = 0;
        hi       = 'x;
        lo       = 'x;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.a         = a;
        bus.b         = b;
        bus.is_signed = sgn;
        @(posedge clk);
        @(negedge clk);
        bus.start     = 1'b0;
        bus.a         = $urandom;
        bus.b         = $urandom;
        bus.is_signed = ~sgn;
        if (bus.busy !== 1'b1) bad_busy++;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.busy !== (k <= 32)) bad_busy++;
            if (bus.busy === 1'b1 && bus.done === 1'b1) bad_busy++;
            if (bus.done === 1'b1) begin
                if (lat < 0) begin
                    lat = k;
                    hi  = bus.hi;
                    lo  = bus.lo;
                end
                ndone++;
            end
        end
    endtask

    task automatic test_reset;
        bus.start     = 1'b1;
        bus.is_signed = 1'b0;
        bus.a         = 32'd3;
        bus.b         = 32'd5;
        rst           = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        n_cmp += 4;
        if (bus.hi !== 32'd0) begin n_bad++; $display("FAIL reset_hi got %h want 0", bus.hi); end
        if (bus.lo !== 32'd0) begin n_bad++; $display("FAIL reset_lo got %h want 0", bus.lo); end
        if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", bus.done); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed;
        logic [31:0] ta  [7] = '{32'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE,
                                 32'h80000000, 32'h80000000, 32'd0};
        logic [31:0] tb  [7] = '{32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd3,
                                 32'h80000000, 32'd1, 32'hFFFFFFFF};
        logic        ts  [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [31:0] thi [7] = '{32'd0, 32'hFFFFFFFE, 32'd0, 32'hFFFFFFFF,
                                 32'h40000000, 32'hFFFFFFFF, 32'd0};
        logic [31:0] tlo [7] = '{32'hF, 32'd1, 32'd1, 32'hFFFFFFFA,
                                 32'd0, 32'h80000000, 32'd0};
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        int          nd;
        int          bb;
        for (int i = 0; i < 7; i++) begin
            run_op(ta[i], tb[i], ts[i], hi, lo, lat, nd, bb);
            n_cmp += 5;
            if (hi !== thi[i]) begin
                n_bad++; $display("FAIL dir%0d_hi got %h want %h", i, hi, thi[i]);
            end
            if (lo !== tlo[i]) begin
                n_bad++; $display("FAIL dir%0d_lo got %h want %h", i, lo, tlo[i]);
            end
            if (lat !== 33) begin
                n_bad++; $display("FAIL dir%0d_latency got %0d want 33", i, lat);
            end
            if (nd !== 1) begin
                n_bad++; $display("FAIL dir%0d_done_count got %0d want 1", i, nd);
            end
            if (bb !== 0) begin
                n_bad++; $display("FAIL dir%0d_busy_profile got %0d errors want 0", i, bb);
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [63:0] exp_p;
        int          lat;
        int          nd;
        int          bb;
        for (int i = 0; i < 20; i++) begin
            a   = $urandom;
            b   = $urandom;
            sgn = 1'($urandom_range(1, 0));
            if (i % 5 == 1) a = {a[31], 31'd0};
            if (i % 7 == 2) b = 32'hFFFFFFFF;
            exp_p = ref_mul(a, b, sgn);
            run_op(a, b, sgn, hi, lo, lat, nd, bb);
            n_cmp += 2;
            if ({hi, lo} !== exp_p) begin
                n_bad++;
                $display("FAIL rand%0d_product a=%h b=%h s=%b got %h want %h",
                         i, a, b, sgn, {hi, lo}, exp_p);
            end
            if (lat !== 33 || nd !== 1 || bb !== 0) begin
                n_bad++;
                $display("FAIL rand%0d_timing got lat=%0d done=%0d busyerr=%0d want 33/1/0",
                         i, lat, nd, bb);
            end
        end
    endtask

    task automatic test_back_to_back;
        int          nd = 0;
        int          e1 = -1;
        int          e2 = -1;
        logic [63:0] p1 = 'x;
        logic [63:0] p2 = 'x;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.is_signed = 1'b0;
        bus.a         = 32'd7;
        bus.b         = 32'd9;
        @(posedge clk);
        @(negedge clk);
        bus.a = 32'h12345678;
        bus.b = 32'h12345678;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 34) bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                nd++;
                if (e1 < 0) begin
                    e1 = k; p1 = {bus.hi, bus.lo};
                end else if (e2 < 0) begin
                    e2 = k; p2 = {bus.hi, bus.lo};
                end
            end
        end
        n_cmp += 5;
        if (p1 !== 64'd63) begin n_bad++; $display("FAIL b2b_first got %h want 63", p1); end
        if (e1 !== 33) begin n_bad++; $display("FAIL b2b_first_edge got %0d want 33", e1); end
        if (p2 !== 64'h014B66DC_1DF4D840) begin
            n_bad++; $display("FAIL b2b_second got %h want 014b66dc1df4d840", p2);
        end
        if (e2 !== 67) begin n_bad++; $display("FAIL b2b_second_edge got %0d want 67", e2); end
        if (nd !== 2) begin n_bad++; $display("FAIL b2b_done_count got %0d want 2", nd); end
    endtask

    task automatic test_reset_midrun;
        int          nd = 0;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        int          nd2;
        int          bb;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.is_signed = 1'b0;
        bus.a         = 32'hFFFF;
        bus.b         = 32'hFFFF;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        n_cmp += 4;
        if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
        if (bus.hi !== 32'd0) begin n_bad++; $display("FAIL midrst_hi got %h want 0", bus.hi); end
        if (bus.lo !== 32'd0) begin n_bad++; $display("FAIL midrst_lo got %h want 0", bus.lo); end
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done === 1'b1) nd++;
        end
        if (nd !== 0) begin n_bad++; $display("FAIL midrst_no_done got %0d want 0", nd); end
        run_op(32'd2, 32'd2, 1'b0, hi, lo, lat, nd2, bb);
        n_cmp += 2;
        if ({hi, lo} !== 64'd4) begin
            n_bad++; $display("FAIL midrst_after got %h want 4", {hi, lo});
        end
        if (lat !== 33) begin n_bad++; $display("FAIL midrst_after_latency got %0d want 33", lat); end
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
